// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths, constants and fetch-queue entry type for the fetch stage
// FETCH_MISALIGN_CHK_EN adds the misalign flag to each queued entry.
package riscv_pkg;

   localparam int              XLEN             = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
`ifdef FETCH_MISALIGN_CHK_EN
      logic            misalign;
`endif
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry circular fetch queue with flush, push, pop and occupancy count
module fetch_queue
   import riscv_pkg::*;
(
   input  logic               clk,
   input  logic               resetn,
   input  logic               i_flush,
   input  logic               i_push,
   input  logic [ENTRY_W-1:0] i_push_data,
   input  logic               i_pop,
   output logic [ENTRY_W-1:0] o_head,
   output logic [1:0]         o_count
);

   logic [ENTRY_W-1:0] r_mem [2];
   logic               r_rd_ptr;
   logic               r_wr_ptr;
   logic [1:0]         r_count;
   logic               w_pop;

   assign w_pop   = i_pop & (r_count != 2'd0);
   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   // Storage is cleared on reset so the head reads as zero before anything arrives.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (i_flush) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/riscv_fetch_stage.sv
// rtl/riscv_fetch_stage.sv - instruction fetch: PC, credit-limited imem issue, redirect, 2-entry queue
// Define FETCH_MISALIGN_CHK_EN to add if_misalign on the first entry after a misaligned redirect.
module riscv_fetch_stage #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT,
   parameter int              QDEPTH   = 2
) (
   input  logic            clk,
   input  logic            resetn,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            id_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc_plus4
`ifdef FETCH_MISALIGN_CHK_EN
   ,
   output logic            if_misalign
`endif
);
   import riscv_pkg::*;

   localparam logic [2:0] LP_QDEPTH = 3'(QDEPTH);

   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_pend_pc;
   logic            r_pending;
   logic            r_pend_kill;

   logic            w_pop;
   logic            w_issue;
   logic            w_push;
   logic [2:0]      w_credit;
   logic [1:0]      w_count;
   fetch_entry_t    w_push_entry;
   fetch_entry_t    w_head;

   assign w_pop    = if_valid & id_ready;
   // Queued entries plus the one in flight, less the one leaving, must stay below the queue depth.
   assign w_credit = {1'b0, w_count} + {2'b00, r_pending} - {2'b00, w_pop};
   assign w_issue  = resetn & ~redirect_valid & (w_credit < LP_QDEPTH);
   assign w_push   = r_pending & ~r_pend_kill & ~redirect_valid;

   assign imem_req  = w_issue;
   assign imem_addr = align_pc(r_fetch_pc);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_fetch_pc  <= RESET_PC;
         r_pend_pc   <= '0;
         r_pending   <= 1'b0;
         r_pend_kill <= 1'b0;
      end else begin
         r_pending   <= w_issue;
         r_pend_kill <= redirect_valid & w_issue;
         if (redirect_valid) begin
            r_fetch_pc <= align_pc(redirect_pc);
         end else if (w_issue) begin
            r_fetch_pc <= r_fetch_pc + XLEN'(4);
            r_pend_pc  <= r_fetch_pc;
         end
      end
   end

`ifdef FETCH_MISALIGN_CHK_EN
   logic r_mis_armed;
   logic r_pend_mis;

   // The flag rides on the first request issued after a misaligned redirect.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_mis_armed <= 1'b0;
         r_pend_mis  <= 1'b0;
      end else if (redirect_valid) begin
         r_mis_armed <= |redirect_pc[1:0];
         r_pend_mis  <= 1'b0;
      end else if (w_issue) begin
         r_pend_mis  <= r_mis_armed;
         r_mis_armed <= 1'b0;
      end
   end

   assign if_misalign = w_head.misalign;
`else
   logic w_unused_pc_lsb;
   assign w_unused_pc_lsb = ^redirect_pc[1:0];
`endif

   always_comb begin
      w_push_entry       = '0;
      w_push_entry.pc    = r_pend_pc;
      w_push_entry.instr = imem_rdata;
`ifdef FETCH_MISALIGN_CHK_EN
      w_push_entry.misalign = r_pend_mis;
`endif
   end

   fetch_queue u_queue (
      .clk         (clk),
      .resetn      (resetn),
      .i_flush     (redirect_valid),
      .i_push      (w_push),
      .i_push_data (w_push_entry),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_count     (w_count)
   );

   assign if_valid    = (w_count != 2'd0);
   assign if_pc       = w_head.pc;
   assign if_instr    = w_head.instr;
   assign if_pc_plus4 = w_head.pc + XLEN'(4);

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// tb/tb_riscv_fetch_stage.sv - randomized and directed bench for riscv_fetch_stage against a stream-level model
module tb_riscv_fetch_stage;

   logic        clk;
   logic        resetn;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        id_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic [31:0] if_pc_plus4;
`ifdef FETCH_MISALIGN_CHK_EN
   logic        if_misalign;
   logic        w_if_misalign;
`endif

   logic        w_imem_req;
   logic [31:0] w_imem_addr;
   logic [31:0] w_imem_rdata;
   logic        w_id_ready;
   logic        w_redirect_valid;
   logic [31:0] w_redirect_pc;
   logic        w_if_valid;
   logic [31:0] w_if_pc;
   logic [31:0] w_if_instr;
   logic [31:0] w_if_pc_plus4;

   riscv_fetch_stage u_dut (
      .clk            (clk),
      .resetn         (resetn),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .id_ready       (id_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .if_pc_plus4    (if_pc_plus4)
`ifdef FETCH_MISALIGN_CHK_EN
      ,
      .if_misalign    (if_misalign)
`endif
   );

   riscv_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk            (clk),
      .resetn         (resetn),
      .imem_req       (w_imem_req),
      .imem_addr      (w_imem_addr),
      .imem_rdata     (w_imem_rdata),
      .id_ready       (w_id_ready),
      .redirect_valid (w_redirect_valid),
      .redirect_pc    (w_redirect_pc),
      .if_valid       (w_if_valid),
      .if_pc          (w_if_pc),
      .if_instr       (w_if_instr),
      .if_pc_plus4    (w_if_pc_plus4)
`ifdef FETCH_MISALIGN_CHK_EN
      ,
      .if_misalign    (w_if_misalign)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous instruction memory: data is a function of the address, junk when idle.
   always @(posedge clk) begin
      imem_rdata   <= imem_req   ? (imem_addr   ^ 32'hA5A5_0000) : riscv_pkg::NOP_INSTR;
      w_imem_rdata <= w_imem_req ? (w_imem_addr ^ 32'hA5A5_0000) : riscv_pkg::NOP_INSTR;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Stream-level model: next PC to deliver, next PC to request, outstanding instructions.
   logic [31:0] exp_pc;
   logic [31:0] exp_fetch;
   int          occ;
   logic        last_req;
   logic [31:0] last_addr;
`ifdef FETCH_MISALIGN_CHK_EN
   logic        exp_mis;
`endif

   task automatic model_reset(input logic [31:0] pc);
      exp_pc    = pc;
      exp_fetch = pc;
      occ       = 0;
`ifdef FETCH_MISALIGN_CHK_EN
      exp_mis   = 1'b0;
`endif
   endtask

   task automatic model_step();
      logic pop;
      logic exp_req;
      pop     = if_valid & id_ready;
      exp_req = !redirect_valid && ((occ - int'(pop)) < 2);
      check("imem_req", imem_req, exp_req);
      if (exp_req) begin
         check("imem_addr", imem_addr, exp_fetch);
         exp_fetch = exp_fetch + 32'd4;
      end
      if (occ == 0) check("empty_valid", if_valid, 1'b0);
      if (if_valid) begin
         check("head_pc", if_pc, exp_pc);
         check("head_instr", if_instr, exp_pc ^ 32'hA5A5_0000);
         check("head_pc_plus4", if_pc_plus4, exp_pc + 32'd4);
`ifdef FETCH_MISALIGN_CHK_EN
         check("head_misalign", if_misalign, exp_mis);
`endif
      end
      if (pop) begin
         exp_pc = exp_pc + 32'd4;
`ifdef FETCH_MISALIGN_CHK_EN
         exp_mis = 1'b0;
`endif
      end
      if (redirect_valid) begin
         exp_pc    = {redirect_pc[31:2], 2'b00};
         exp_fetch = exp_pc;
         occ       = 0;
`ifdef FETCH_MISALIGN_CHK_EN
         exp_mis   = |redirect_pc[1:0];
`endif
      end else begin
         occ = occ + int'(exp_req) - int'(pop);
      end
   endtask

   task automatic do_cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
      id_ready       = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      @(negedge clk);
      model_step();
      last_req  = imem_req;
      last_addr = imem_addr;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] w_pcs [$];
   logic [31:0] w_plus4_at_fc = 32'hDEAD_BEEF;
   logic [31:0] w_exp [3];

   always @(negedge clk) begin
      if (resetn && w_if_valid && w_pcs.size() < 3) begin
         w_pcs.push_back(w_if_pc);
         if (w_if_pc == 32'hFFFF_FFFC) w_plus4_at_fc = w_if_pc_plus4;
      end
   end

   initial begin
      int          first_v;
      int          seen200;
      int          nvalid;
      logic [31:0] first_pc;

      resetn           = 1'b0;
      id_ready         = 1'b0;
      redirect_valid   = 1'b0;
      redirect_pc      = '0;
      w_id_ready       = 1'b1;
      w_redirect_valid = 1'b0;
      w_redirect_pc    = '0;
      w_exp[0] = 32'hFFFF_FFF8;
      w_exp[1] = 32'hFFFF_FFFC;
      w_exp[2] = 32'h0000_0000;
      model_reset(32'h0);

      repeat (3) @(posedge clk);
      #3;
      check("reset_if_valid", if_valid, 1'b0);
      check("reset_if_pc", if_pc, 32'h0);
      check("reset_if_instr", if_instr, 32'h0);
      check("reset_imem_req", imem_req, 1'b0);
      resetn = 1'b1;

      // Start-up latency and streaming up to PC 8
      first_v = -1;
      for (int c = 0; c < 12; c++) begin
         if (if_valid && first_v < 0) first_v = c;
         if (if_valid && if_pc == 32'h8) break;
         do_cycle(1'b1, 1'b0, '0);
      end
      check("first_valid_cycle", 32'(first_v), 32'd2);
      check("stall_head_reached", if_pc, 32'h8);

      for (int k = 0; k < 5; k++) begin
         check("stall_hold_pc", if_pc, 32'h8);
         check("stall_hold_instr", if_instr, 32'h8 ^ 32'hA5A5_0000);
         do_cycle(1'b0, 1'b0, '0);
         check("stall_no_req", last_req, 1'b0);
      end
      for (int k = 0; k < 3; k++) begin
         check("release_valid", if_valid, 1'b1);
         check("release_pc", if_pc, 32'h8 + 32'(4 * k));
         do_cycle(1'b1, 1'b0, '0);
      end

      check("wrap_count", 32'(w_pcs.size()), 32'd3);
      for (int i = 0; i < w_pcs.size(); i++) check("wrap_pc", w_pcs[i], w_exp[i]);
      check("wrap_plus4", w_plus4_at_fc, 32'h0);

      // Redirect with a full queue, then with one response in flight
      for (int k = 0; k < 3; k++) do_cycle(1'b0, 1'b0, '0);
      check("full_before_redirect", if_valid, 1'b1);
      do_cycle(1'b0, 1'b1, 32'h100);
      check("rd_t1_valid", if_valid, 1'b0);
      do_cycle(1'b1, 1'b0, '0);
      check("rd_t1_req", last_req, 1'b1);
      check("rd_t1_addr", last_addr, 32'h100);
      check("rd_t2_valid", if_valid, 1'b0);
      do_cycle(1'b1, 1'b0, '0);
      check("rd_t3_valid", if_valid, 1'b1);
      check("rd_t3_pc", if_pc, 32'h100);
      check("rd_t3_plus4", if_pc_plus4, 32'h104);
      do_cycle(1'b1, 1'b0, '0);

      do_cycle(1'b1, 1'b1, 32'h200);
      do_cycle(1'b1, 1'b1, 32'h300);
      seen200  = 0;
      first_pc = 32'hFFFF_FFFF;
      for (int k = 0; k < 8; k++) begin
         if (if_valid && if_pc == 32'h200) seen200++;
         if (if_valid && first_pc == 32'hFFFF_FFFF) first_pc = if_pc;
         do_cycle(1'b1, 1'b0, '0);
      end
      check("b2b_no_200", 32'(seen200), 32'd0);
      check("b2b_first_pc", first_pc, 32'h300);

`ifdef FETCH_MISALIGN_CHK_EN
      do_cycle(1'b1, 1'b1, 32'h102);
      for (int k = 0; k < 6; k++) begin
         if (if_valid) break;
         do_cycle(1'b1, 1'b0, '0);
      end
      check("mis_pc", if_pc, 32'h100);
      check("mis_flag", if_misalign, 1'b1);
      do_cycle(1'b1, 1'b0, '0);
      check("mis_next_pc", if_pc, 32'h104);
      check("mis_next_flag", if_misalign, 1'b0);
`endif

      // Asynchronous reset with a full queue
      for (int k = 0; k < 3; k++) do_cycle(1'b0, 1'b0, '0);
      check("full_before_reset", if_valid, 1'b1);
      #2;
      resetn = 1'b0;
      #1;
      check("async_if_valid", if_valid, 1'b0);
      check("async_imem_req", imem_req, 1'b0);
      check("async_if_pc", if_pc, 32'h0);
      repeat (2) @(posedge clk);
      #3;
      resetn = 1'b1;
      model_reset(32'h0);
      do_cycle(1'b1, 1'b0, '0);
      check("restart_req", last_req, 1'b1);
      check("restart_addr", last_addr, 32'h0);
      for (int k = 0; k < 4; k++) do_cycle(1'b1, 1'b0, '0);

      for (int i = 0; i < 1500; i++) begin
         do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom);
      end

      nvalid = 0;
      for (int k = 0; k < 10; k++) begin
         if (if_valid) nvalid++;
         do_cycle(1'b1, 1'b0, '0);
      end
      check("drain_flow", 32'(nvalid >= 7), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
